// File: rtl/byte_serial_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package byte_serial_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the byte index counter for an NBYTES-wide operand.
  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes < 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/byte_skip_adder.sv
// 8-bit carry-skip adder: two 4-bit ripple groups, each bypassed when every
// bit in the group propagates.
module byte_skip_adder
  import byte_serial_pkg::*;
(
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin
);

  logic [BYTE_W-1:0] p;
  logic [BYTE_W-1:0] g;
  logic              c;
  logic              c_mid;

  assign p = a ^ b;
  assign g = a & b;

  // Ripple within each group; skip muxes select the group carry-in when the group fully propagates.
  always_comb begin
    sum   = '0;
    c     = cin;
    c_mid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = p[i] ^ c;
      c      = g[i] | (p[i] & c);
    end
    c_mid = (&p[3:0]) ? cin : c;
    c     = c_mid;
    for (int i = 4; i < 8; i++) begin
      sum[i] = p[i] ^ c;
      c      = g[i] | (p[i] & c);
    end
    cout = (&p[7:4]) ? c_mid : c;
  end

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial multi-precision adder: adds two NBYTES-wide operands one byte
// per cycle, LSB first, through a single 8-bit carry-skip adder.
// Optional macro BYTE_SERIAL_SUB_EN adds in_sub for A-B subtraction.
module byte_serial_adder
  import byte_serial_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] in_a,
  input  logic [BYTE_W*NBYTES-1:0] in_b,
  input  logic                     in_cin,
`ifdef BYTE_SERIAL_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy
);

  localparam int unsigned W     = BYTE_W * NBYTES;
  localparam int unsigned IDX_W = idx_width(NBYTES);

  state_t             state_q;
  state_t             state_n;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic [BYTE_W-1:0]  a_byte;
  logic [BYTE_W-1:0]  b_byte;
  logic [BYTE_W-1:0]  b_in;
  logic [BYTE_W-1:0]  adder_sum;
  logic               adder_cout;
  logic               last_byte;
  logic               carry_init;

`ifdef BYTE_SERIAL_SUB_EN
  logic               sub_q;
  assign b_in       = sub_q ? ~b_byte : b_byte;
  assign carry_init = in_sub ? 1'b1 : in_cin;
`else
  assign b_in       = b_byte;
  assign carry_init = in_cin;
`endif

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  // Select the operand bytes addressed by the current byte index.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte = a_q[i*BYTE_W +: BYTE_W];
        b_byte = b_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  byte_skip_adder u_adder (
    .sum  (adder_sum),
    .cout (adder_cout),
    .a    (a_byte),
    .b    (b_in),
    .cin  (carry_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last_byte) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Operand capture, byte index, inter-byte carry and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef BYTE_SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= carry_init;
            idx_q   <= '0;
            sum_q   <= '0;
`ifdef BYTE_SERIAL_SUB_EN
            sub_q   <= in_sub;
`endif
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
              sum_q[i*BYTE_W +: BYTE_W] <= adder_sum;
            end
          end
          carry_q <= adder_cout;
          if (last_byte) begin
            cout_q <= adder_cout;
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status are decoded from the state register only; in_ready
  // is also held low while reset is asserted.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) | (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder (NBYTES=4): directed corner cases
// followed by randomized operations under random backpressure.
module tb_byte_serial_adder;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef BYTE_SERIAL_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           rdy_mode = 1;   // 0: low, 1: high, 2: random
  logic [W:0]   exp_q[$];

  byte_serial_adder #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef BYTE_SERIAL_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: full-precision arithmetic on the whole words.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    end
    return r;
  endfunction

  // out_ready driver, updated away from the sampling edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every presented result against the scoreboard head.
  initial begin
    int   acc_cyc;
    logic prev_valid;
    acc_cyc    = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) acc_cyc = cyc;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("out_sum", 64'(out_sum), 64'(exp_q[0][W-1:0]));
          check("out_cout", 64'(out_cout), 64'(exp_q[0][W]));
          if (!prev_valid) check("latency", 64'(cyc - acc_cyc), 64'(NBYTES + 1));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // Issue one operation; called just after a rising edge. Leaves in_valid high if hold.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input logic hold);
    int n;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef BYTE_SERIAL_SUB_EN
    in_sub   = sub;
`endif
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
`ifdef BYTE_SERIAL_SUB_EN
      exp_q.push_back(model(a, b, cin, sub));
`else
      exp_q.push_back(model(a, b, cin, 1'b0));
`endif
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    #3;
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Byte-boundary and full-width carry propagation.
    rdy_mode = 1;
    send(32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    drain();
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();

    // Backpressure: result held while out_ready stays low.
    rdy_mode = 0;
    @(posedge clk); #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a run discards the partial result.
    send(32'hDEAD_BEEF, 32'h0102_0304, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_sum", 64'(out_sum), 64'd0);
    check("mid_rst_out_cout", 64'(out_cout), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < NBYTES + 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Back-to-back with in_valid held; new operands while busy are ignored.
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drain();

`ifdef BYTE_SERIAL_SUB_EN
    send(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
    send(32'd7, 32'd5, 1'b1, 1'b1, 1'b0);
    drain();
`endif

    // Randomized operations under random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 3) == 0) ra = '1;
      if ($urandom_range(0, 5) == 0) rb = '0;
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
